// File: rtl/sum_latch_pkg.sv
// Shared definitions for the sum-latch UART sequencer.
//   state_e     : sequencer states
//   FRAME_BITS  : UART 8N1 frame length (start + 8 data + stop)
//   OP_W/SUM_W  : operand and sum widths of the external adder
package sum_latch_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned OP_W       = 4;
  localparam int unsigned SUM_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SEND_OPS,
    WAIT_OPS,
    SEND_SUM,
    WAIT_SUM,
    DONE
  } state_e;

endpackage

// File: rtl/sum_latch_uart_ctrl_uart_tx.sv
// UART 8N1 transmitter.
//   clk, rst  : clock, synchronous active-high reset
//   tx_start  : load tx_data and begin a frame (ignored while busy)
//   tx_data   : byte to send, LSB first
//   txd       : registered serial output, idle high
//   tx_busy   : frame in progress
//   tx_done   : high in the last cycle of the stop bit
module uart_tx_8n1
  import sum_latch_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] frame_q;
  logic [CNT_W-1:0]      baud_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  active_q;
  logic                  txd_q;
  logic                  bit_end;

  assign bit_end = active_q && (baud_q == BAUD_LAST);

  // frame_q[0] always holds the bit currently on the line; shifting in ones
  // keeps the line high once the stop bit has been consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q  <= '1;
      baud_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      txd_q    <= 1'b1;
    end else if (tx_start && !active_q) begin
      frame_q  <= {1'b1, tx_data, 1'b0};
      baud_q   <= '0;
      idx_q    <= '0;
      active_q <= 1'b1;
      txd_q    <= 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q <= '0;
        if (idx_q == IDX_LAST) begin
          active_q <= 1'b0;
          idx_q    <= '0;
          txd_q    <= 1'b1;
        end else begin
          idx_q   <= idx_q + 1'b1;
          frame_q <= {1'b1, frame_q[FRAME_BITS-1:1]};
          txd_q   <= frame_q[1];
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

  assign txd     = txd_q;
  assign tx_busy = active_q;
  assign tx_done = bit_end && (idx_q == IDX_LAST);

endmodule

// File: rtl/sum_latch_uart_ctrl.sv
// Sequencer for the external 4-bit adder: latches operands on start, captures
// the 5-bit sum, then sends {b,a} and {3'b000,sum} as two UART 8N1 frames.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, sampled only in IDLE
//   a_in, b_in      : operands from pins
//   add_a, add_b    : registered operands to the adder
//   add_sum         : adder result
//   sum_q           : latched sum
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse after the second stop bit
//   uart_txd        : serial line, idle high
module sum_latch_uart_ctrl
  import sum_latch_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  a_in,
  input  logic [OP_W-1:0]  b_in,
  output logic [OP_W-1:0]  add_a,
  output logic [OP_W-1:0]  add_b,
  input  logic [SUM_W-1:0] add_sum,
  output logic [SUM_W-1:0] sum_q,
  output logic             busy,
  output logic             done,
  output logic             uart_txd
);

  state_e           state_q;
  logic [OP_W-1:0]  add_a_q;
  logic [OP_W-1:0]  add_b_q;
  logic [SUM_W-1:0] sum_lat_q;
  logic             busy_q;
  logic             done_q;

  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic             tx_done;

  // The send states last one cycle and are only entered with the
  // transmitter idle, so the tx_busy gate never actually suppresses a start.
  assign tx_start = ((state_q == SEND_OPS) || (state_q == SEND_SUM)) && !tx_busy;
  assign tx_data  = (state_q == SEND_OPS) ? {add_b_q, add_a_q} : {3'b000, sum_lat_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      add_a_q   <= '0;
      add_b_q   <= '0;
      sum_lat_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            add_a_q <= a_in;
            add_b_q <= b_in;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          sum_lat_q <= add_sum;
          state_q   <= SEND_OPS;
        end
        SEND_OPS: state_q <= WAIT_OPS;
        WAIT_OPS: if (tx_done) state_q <= SEND_SUM;
        SEND_SUM: state_q <= WAIT_SUM;
        WAIT_SUM: begin
          if (tx_done) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .txd     (uart_txd),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  assign add_a = add_a_q;
  assign add_b = add_b_q;
  assign sum_q = sum_lat_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sum_latch_uart_ctrl.sv
module tb_sum_latch_uart_ctrl;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;
  // Observation index j counts negedges after the edge that accepts start.
  // Frame 1 occupies j=2..2+FRAME-1, frame 2 j=3+FRAME..2+2*FRAME,
  // done is seen at j=3+2*FRAME, IDLE at j=LAST.
  localparam int unsigned LAST  = 4 + 2 * FRAME;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_in, b_in, add_a, add_b;
  logic [4:0] add_sum, sum_q;
  logic       busy, done, uart_txd;

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  sum_latch_uart_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum),
    .sum_q   (sum_q),
    .busy    (busy),
    .done    (done),
    .uart_txd(uart_txd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Independent mid-bit UART receiver; frames touched by reset are dropped.
  logic [7:0] rx_q[$];
  initial begin
    logic [7:0] d;
    logic       ok;
    forever begin
      @(negedge uart_txd);
      ok = !rst;
      repeat (CPB / 2) @(posedge clk);
      if (uart_txd !== 1'b0 || rst) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        d[i] = uart_txd;
        if (rst) ok = 1'b0;
      end
      repeat (CPB) @(posedge clk);
      if (uart_txd !== 1'b1 || rst) ok = 1'b0;
      if (ok) rx_q.push_back(d);
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp_sum;
    logic [7:0] exp_ops;
    logic [7:0] exp_sbyte;
    bit         noise;
    bit         hold;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t model(input logic [3:0] a, input logic [3:0] b,
                                 input bit noise, input bit hold);
    vec_t v;
    int unsigned s;
    s           = int'(a) + int'(b);
    v.a         = a;
    v.b         = b;
    v.exp_sum   = 5'(s);
    v.exp_ops   = 8'(int'(b) * 16 + int'(a));
    v.exp_sbyte = 8'(s);
    v.noise     = noise;
    v.hold      = hold;
    return v;
  endfunction

  // Expected line level at observation j for a transaction sending f1 then f2.
  function automatic logic exp_txd(input int unsigned j, input logic [7:0] f1,
                                   input logic [7:0] f2);
    logic [9:0] fr;
    if (j >= 2 && j < 2 + FRAME) begin
      fr = {1'b1, f1, 1'b0};
      return fr[(j - 2) / CPB];
    end
    if (j >= 3 + FRAME && j < 3 + 2 * FRAME) begin
      fr = {1'b1, f2, 1'b0};
      return fr[(j - 3 - FRAME) / CPB];
    end
    return 1'b1;
  endfunction

  task automatic run_txn(input vec_t v, input int idx);
    int txd_err  = 0;
    int busy_err = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic [7:0] r0, r1;
    a_in  = v.a;
    b_in  = v.b;
    start = 1'b1;
    for (int unsigned j = 0; j <= LAST; j++) begin
      @(negedge clk);
      if (uart_txd !== exp_txd(j, v.exp_ops, v.exp_sbyte)) txd_err++;
      if (busy !== (j < LAST)) busy_err++;
      if (done !== 1'b0) begin
        done_cnt++;
        done_at = int'(j);
      end
      if (j < LAST) begin
        if (v.noise) begin
          start = 1'($urandom_range(0, 1));
          a_in  = 4'($urandom);
          b_in  = 4'($urandom);
        end else if (!v.hold) begin
          start = 1'b0;
        end
      end else begin
        start = v.hold;
      end
    end
    chk($sformatf("v%0d txd_waveform_errs", idx), txd_err, 0);
    chk($sformatf("v%0d busy_profile_errs", idx), busy_err, 0);
    chk($sformatf("v%0d done_pulses", idx), done_cnt, 1);
    chk($sformatf("v%0d done_at", idx), done_at, LAST - 1);
    chk($sformatf("v%0d sum_q", idx), sum_q, v.exp_sum);
    chk($sformatf("v%0d operands", idx), {add_b, add_a}, v.exp_ops);
    chk($sformatf("v%0d rx_count", idx), rx_q.size(), 2);
    r0 = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    r1 = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    chk($sformatf("v%0d rx_ops_byte", idx), r0, v.exp_ops);
    chk($sformatf("v%0d rx_sum_byte", idx), r1, v.exp_sbyte);
    rx_q.delete();
    if (!v.hold) @(negedge clk);
  endtask

  initial begin
    int dcnt;
    int tbad;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    vecs[0] = '{4'h3, 4'h5, 5'h08, 8'h53, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{4'hF, 4'hF, 5'h1E, 8'hFF, 8'h1E, 1'b0, 1'b0};
    vecs[2] = '{4'hA, 4'h7, 5'h11, 8'h7A, 8'h11, 1'b1, 1'b0};
    vecs[3] = '{4'h2, 4'hC, 5'h0E, 8'hC2, 8'h0E, 1'b0, 1'b1};
    vecs[4] = '{4'h9, 4'h4, 5'h0D, 8'h49, 8'h0D, 1'b0, 1'b0};
    for (int i = 5; i < 10; i++)
      vecs[i] = model(4'($urandom), 4'($urandom), (i == 7), 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset uart_txd", uart_txd, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum_q", sum_q, 0);
    chk("reset add_a_b", {add_b, add_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset busy", busy, 0);

    for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

    // Reset in the middle of data bit 3 of frame 1
    a_in  = 4'h6;
    b_in  = 4'h9;
    start = 1'b1;
    for (int unsigned j = 0; j <= 2 + 4 * CPB + 1; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midreset uart_txd", uart_txd, 1);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset operands cleared", {add_b, add_a}, 0);
    chk("midreset sum cleared", sum_q, 0);
    rst  = 1'b0;
    dcnt = 0;
    tbad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done !== 1'b0) dcnt++;
      if (uart_txd !== 1'b1) tbad++;
      if (busy !== 1'b0) tbad++;
    end
    chk("postreset done pulses", dcnt, 0);
    chk("postreset line/busy idle errs", tbad, 0);
    rx_q.delete();
    run_txn(model(4'h6, 4'h9, 1'b0, 1'b0), 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, required completion before it");
    $fatal(1, "timeout");
  end

endmodule
